td4x_core: RTL and testbench

Parametrised successor to the 4-bit TD4 core. It adds configurable data and program-counter widths, a req/ack instruction-fetch handshake so program memory may insert wait states, and three new opcodes: OUT A, JC and HALT. The block sits between the top level, the program memory and the switch/LED ports, and executes one instruction per fetch/execute pair.

---
 rtl/td4x_core.sv | 139 +++++++++++++
 tb/tb_td4x_core.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/td4x_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | td4x_core : parametrised TD4-style CPU core with req/ack instruction fetch  |
// | Revision  : 1.0                                                            |
// +----------------------------------------------------------------------------+
module td4x_core #(
    parameter int DW = 4,
    parameter int AW = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [DW-1:0] sw,
    output logic [DW-1:0] LED,
    output logic          led_valid,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ack,
    input  logic [DW+3:0] imem_data,
    output logic          halted
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    localparam logic [AW-1:0] c_PC_ONE = {{(AW-1){1'b0}}, 1'b1};

    state_t        r_state, w_state_nxt;
    logic [DW-1:0] r_a, r_b, r_led;
    logic [DW-1:0] w_a_nxt, w_b_nxt, w_led_nxt;
    logic [AW-1:0] r_pc, w_pc_nxt;
    logic          r_c, w_c_nxt;
    logic [DW+3:0] r_ir, w_ir_nxt;
    logic          r_led_valid, w_led_valid_nxt;

    logic [3:0]    w_op;
    logic [DW-1:0] w_imm;
    logic [DW-1:0] w_src;
    logic [DW:0]   w_sum;
    logic          w_take;

    assign w_op  = r_ir[DW+3:DW];
    assign w_imm = r_ir[DW-1:0];

    // Source operand select; jumps, NOP and immediate moves add to zero.
    always_comb begin
        w_src = '0;
        case (w_op)
            4'b0000, 4'b0100, 4'b1010: w_src = r_a;
            4'b0001, 4'b0101, 4'b1001: w_src = r_b;
            4'b0010, 4'b0110:          w_src = sw;
            default:                   w_src = '0;
        endcase
    end

    assign w_sum = {1'b0, w_src} + {1'b0, w_imm};

    always_comb begin
        w_take = 1'b0;
        case (w_op)
            4'b1110: w_take = ~r_c;
            4'b1100: w_take = r_c;
            4'b1111: w_take = 1'b1;
            default: w_take = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state     <= S_FETCH;
            r_a         <= '0;
            r_b         <= '0;
            r_led       <= '0;
            r_pc        <= '0;
            r_c         <= 1'b0;
            r_ir        <= '0;
            r_led_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_a         <= w_a_nxt;
            r_b         <= w_b_nxt;
            r_led       <= w_led_nxt;
            r_pc        <= w_pc_nxt;
            r_c         <= w_c_nxt;
            r_ir        <= w_ir_nxt;
            r_led_valid <= w_led_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_a_nxt         = r_a;
        w_b_nxt         = r_b;
        w_led_nxt       = r_led;
        w_pc_nxt        = r_pc;
        w_c_nxt         = r_c;
        w_ir_nxt        = r_ir;
        w_led_valid_nxt = 1'b0;
        case (r_state)
            S_FETCH: begin
                if (imem_ack) begin
                    w_ir_nxt    = imem_data;
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                if (w_op == 4'b1101) begin
                    w_state_nxt = S_HALT;
                end else begin
                    w_c_nxt     = w_sum[DW];
                    w_pc_nxt    = w_take ? w_sum[AW-1:0] : r_pc + c_PC_ONE;
                    w_state_nxt = S_FETCH;
                    case (w_op)
                        4'b0000, 4'b0001, 4'b0010, 4'b0011: w_a_nxt = w_sum[DW-1:0];
                        4'b0100, 4'b0101, 4'b0110, 4'b0111: w_b_nxt = w_sum[DW-1:0];
                        4'b1001, 4'b1010, 4'b1011: begin
                            w_led_nxt       = w_sum[DW-1:0];
                            w_led_valid_nxt = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            S_HALT:  w_state_nxt = S_HALT;
            default: w_state_nxt = S_FETCH;
        endcase
    end

    // Fetch-side outputs come from registered state only.
    assign imem_req  = (r_state == S_FETCH);
    assign imem_addr = r_pc;
    assign halted    = (r_state == S_HALT);
    assign LED       = r_led;
    assign led_valid = r_led_valid;

endmodule
`default_nettype wire

// File: tb/tb_td4x_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_td4x_core : directed self-checking bench for td4x_core (4/4 and 8/6)    |
// | Revision     : 1.0                                                         |
// +----------------------------------------------------------------------------+
module tb_td4x_core;

    logic        clk;
    int          checks;
    int          failures;

    logic        rst4, ack4, lv4, req4, halt4;
    logic [3:0]  sw4, led4, addr4;
    logic [7:0]  data4;
    logic [7:0]  prog4 [16];

    logic        rst8, ack8, lv8, req8, halt8;
    logic [7:0]  sw8, led8;
    logic [5:0]  addr8;
    logic [11:0] data8;
    logic [11:0] prog8 [64];

    assign data4 = prog4[addr4];
    assign data8 = prog8[addr8];

    td4x_core #(.DW(4), .AW(4)) u4 (
        .clock(clk), .reset(rst4), .sw(sw4), .LED(led4), .led_valid(lv4),
        .imem_req(req4), .imem_addr(addr4), .imem_ack(ack4),
        .imem_data(data4), .halted(halt4)
    );

    td4x_core #(.DW(8), .AW(6)) u8 (
        .clock(clk), .reset(rst8), .sw(sw8), .LED(led8), .led_valid(lv8),
        .imem_req(req8), .imem_addr(addr8), .imem_ack(ack8),
        .imem_data(data8), .halted(halt8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fill4(input logic [7:0] v);
        for (int i = 0; i < 16; i++) prog4[i] = v;
    endtask

    task automatic reset4();
        rst4 = 1'b0;
        step(2);
        rst4 = 1'b1;
    endtask

    initial begin
        checks = 0; failures = 0;
        rst4 = 1'b0; ack4 = 1'b1; sw4 = 4'h0;
        rst8 = 1'b0; ack8 = 1'b1; sw8 = 8'h00;
        fill4(8'h3F);
        for (int i = 0; i < 64; i++) prog8[i] = 12'h800;

        // Reset held with an ack and an instruction presented.
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_req", req4, 1);
            chk("rst_addr", addr4, 0);
            chk("rst_led", led4, 0);
            chk("rst_lv", lv4, 0);
            chk("rst_halt", halt4, 0);
        end

        // Zero-wait program, then wait states on MOV B,5, then OUT B.
        fill4(8'h80);
        prog4[0] = 8'h37; prog4[1] = 8'h09; prog4[2] = 8'hE0; prog4[3] = 8'hA0;
        prog4[4] = 8'h75; prog4[5] = 8'h90;
        rst4 = 1'b1;
        step();    chk("zw_exec_req", req4, 0); chk("zw_exec_addr", addr4, 0);
        step();    chk("zw_pc1", addr4, 1);     chk("zw_fetch_req", req4, 1);
        step(2);   chk("zw_pc2", addr4, 2);
        step(2);   chk("jnc_fall", addr4, 3);   chk("zw_lv_low", lv4, 0);
        step(2);   chk("out_a_lv", lv4, 1);     chk("out_a_led", led4, 0); chk("zw_pc4", addr4, 4);
        ack4 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("ws_req", req4, 1);
            chk("ws_addr", addr4, 4);
            chk("ws_lv", lv4, 0);
        end
        ack4 = 1'b1;
        step();    chk("ws_exec_req", req4, 0); chk("ws_exec_addr", addr4, 4);
        step();    chk("ws_pc5", addr4, 5);
        step(2);   chk("out_b_led", led4, 4'h5); chk("out_b_lv", lv4, 1);

        // Jump, wrap, carry and conditional jumps.
        fill4(8'h80);
        prog4[0] = 8'hFF; prog4[15] = 8'h01;
        reset4();
        step(2);   chk("jmp_15", addr4, 15);
        step(2);   chk("wrap_0", addr4, 0);
        prog4[0] = 8'hA0; prog4[1] = 8'h0F; prog4[2] = 8'hC4;
        prog4[4] = 8'hC9; prog4[5] = 8'hE8;
        step(2);   chk("mov_ab_a", led4, 4'h1); chk("wrap_pc1", addr4, 1);
        step(4);   chk("jc_taken", addr4, 4);
        step(2);   chk("jc_not_taken", addr4, 5);
        step(2);   chk("jnc_taken", addr4, 8);

        // IN/OUT, with sw only valid in the EXEC cycle of IN B.
        fill4(8'h80);
        prog4[0] = 8'h20; prog4[1] = 8'hA0; prog4[2] = 8'hB5;
        prog4[3] = 8'h63; prog4[4] = 8'h90;
        sw4 = 4'hA;
        reset4();
        step(4);   chk("in_out_a_led", led4, 4'hA); chk("in_out_a_lv", lv4, 1);
        step();    chk("lv_one_cycle", lv4, 0);
        step();    chk("out_im_led", led4, 4'h5); chk("out_im_lv", lv4, 1);
        sw4 = 4'h0;
        step();
        sw4 = 4'hA;
        step();
        sw4 = 4'h0;
        step(2);   chk("in_b_led", led4, 4'hD);
        rst4 = 1'b0;

        // DW=8 / AW=6: carry out of 8 bits, OUT, then HALT.
        prog8[0] = 12'h301; prog8[1] = 12'h0FF; prog8[2] = 12'hC05;
        prog8[5] = 12'hA00; prog8[6] = 12'h0AB; prog8[7] = 12'hA00; prog8[8] = 12'hD00;
        step();
        rst8 = 1'b1;
        step(6);   chk("w8_jc_carry", addr8, 5);
        step(2);   chk("w8_out_zero", led8, 8'h00); chk("w8_out_lv", lv8, 1);
        step(4);   chk("w8_out_ab", led8, 8'hAB);
        step();    chk("w8_halt_exec", halt8, 0); chk("w8_exec_req", req8, 0);
        step();    chk("w8_halted", halt8, 1);   chk("w8_halt_req", req8, 0);
        step(5);   chk("w8_still_halt", halt8, 1); chk("w8_still_noreq", req8, 0);
        chk("w8_halt_led", led8, 8'hAB); chk("w8_halt_addr", addr8, 8);
        rst8 = 1'b0;
        step();    chk("w8_rst_halt", halt8, 0); chk("w8_rst_req", req8, 1);
        chk("w8_rst_addr", addr8, 0); chk("w8_rst_led", led8, 0);
        rst8 = 1'b1;
        step(2);   chk("w8_restart_pc", addr8, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
